// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one scratchpad memory port between NUM_REQ requesters,
// with a read-modify-write lock that pins the port to one requester between its read and write.
module mem_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   localparam int GID_W  = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_l,
   input  logic [NUM_REQ-1:0]        req_avail,
   input  logic [NUM_REQ-1:0]        req_r_en,
   input  logic [NUM_REQ-1:0]        req_w_en,
   input  logic [NUM_REQ-1:0]        req_read_through,
   input  logic [NUM_REQ-1:0]        req_write_through,
   input  logic [NUM_REQ*ADDR_W-1:0] req_ptr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_store,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [DATA_W-1:0]         req_data_load,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic                      mem_ack,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      lock_active,
   output logic [GID_W-1:0]          grant_id,
   output logic                      err_both
);

   typedef enum logic [1:0] {
      ARB  = 2'd0,
      MEM  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;

   logic [NUM_REQ-1:0]   eligible;
   logic                 pick_valid;
   logic [GID_W-1:0]     pick_id;
   logic [GID_W-1:0]     cand;
   logic [ADDR_W-1:0]    sel_ptr;
   logic [DATA_W-1:0]    sel_data;
   logic                 sel_r;
   logic                 sel_w;
   logic                 sel_rt;
   logic                 sel_wt;
   logic [NUM_REQ-1:0]   grant_onehot;

   logic                 hold_rd;
   logic                 hold_rt;
   logic                 hold_wt;

   // While locked only the holder may win; otherwise search starts just past the last grantee.
   always_comb begin
      eligible   = req_avail & (req_r_en | req_w_en);
      pick_valid = 1'b0;
      pick_id    = grant_id;
      cand       = '0;
      if (lock_active) begin
         pick_valid = eligible[grant_id];
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GID_W'((int'(grant_id) + k) % NUM_REQ);
            if (!pick_valid && eligible[cand]) begin
               pick_valid = 1'b1;
               pick_id    = cand;
            end
         end
      end
   end

   always_comb begin
      sel_ptr  = req_ptr[int'(pick_id)*ADDR_W +: ADDR_W];
      sel_data = req_data_store[int'(pick_id)*DATA_W +: DATA_W];
      sel_r    = req_r_en[pick_id];
      sel_w    = req_w_en[pick_id];
      sel_rt   = req_read_through[pick_id];
      sel_wt   = req_write_through[pick_id];
   end

   assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

   always_comb begin
      state_nxt = state;
      case (state)
         ARB:     if (pick_valid) state_nxt = MEM;
         MEM:     if (mem_ack)    state_nxt = RESP;
         RESP:                    state_nxt = ARB;
         default:                 state_nxt = ARB;
      endcase
   end

   // Memory handshake: mem_req rises with a fully formed command and the command is held
   // unchanged until the cycle mem_ack is high; mem_rdata is taken in that same cycle.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state         <= ARB;
         grant_id      <= GID_W'(NUM_REQ - 1);
         req_done      <= '0;
         req_data_load <= '0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         lock_active   <= 1'b0;
         err_both      <= 1'b0;
         hold_rd       <= 1'b0;
         hold_rt       <= 1'b0;
         hold_wt       <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ARB: begin
               req_done <= '0;
               err_both <= 1'b0;
               if (pick_valid) begin
                  grant_id  <= pick_id;
                  mem_req   <= 1'b1;
                  mem_we    <= sel_w;
                  mem_addr  <= sel_ptr;
                  mem_wdata <= sel_data;
                  hold_rd   <= !sel_w;
                  hold_rt   <= sel_rt && !sel_w;
                  hold_wt   <= sel_wt && sel_w;
                  err_both  <= sel_r && sel_w;
               end
            end
            MEM: begin
               err_both <= 1'b0;
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  req_done <= grant_onehot;
                  if (hold_rd) req_data_load <= mem_rdata;
                  if (hold_rt) lock_active <= 1'b1;
               end
            end
            RESP: begin
               req_done <= '0;
               // Release happens as RESP ends, so the next arbitration already sees it open.
               if (hold_wt) lock_active <= 1'b0;
            end
            default: begin
               req_done <= '0;
               err_both <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model of requesters and memory,
// compared against the DUT every cycle, plus literal checks on logged grants and responses.
module tb_mem_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_l = 1'b0;
   logic [N-1:0]    req_avail = '0;
   logic [N-1:0]    req_r_en = '0;
   logic [N-1:0]    req_w_en = '0;
   logic [N-1:0]    req_read_through = '0;
   logic [N-1:0]    req_write_through = '0;
   logic [N*AW-1:0] req_ptr = '0;
   logic [N*DW-1:0] req_data_store = '0;
   logic [N-1:0]    req_done;
   logic [DW-1:0]   req_data_load;
   logic            mem_req;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            mem_ack = 1'b0;
   logic [DW-1:0]   mem_rdata = '0;
   logic            lock_active;
   logic [1:0]      grant_id;
   logic            err_both;

   mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_l(rst_l),
      .req_avail(req_avail), .req_r_en(req_r_en), .req_w_en(req_w_en),
      .req_read_through(req_read_through), .req_write_through(req_write_through),
      .req_ptr(req_ptr), .req_data_store(req_data_store),
      .req_done(req_done), .req_data_load(req_data_load),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .lock_active(lock_active), .grant_id(grant_id), .err_both(err_both)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  id;
      logic        r, w, rt, wt;
      logic [31:0] ptr, data, rdata;
      logic [7:0]  delay;
   } access_t;

   access_t pend_q[$];

   int n_checks = 0;
   int n_err = 0;
   int cyc = 0;
   bit jitter = 0;

   // model of the port: who holds it, whether memory has answered, lock and load register
   int      m_gid;
   bit      m_lock;
   logic [31:0] m_load;
   bit      m_act, m_acked, m_first;
   int      m_cnt;
   access_t m_tx;

   // logs of what the DUT did, for the literal checks
   int          dut_grants[$];
   int          rise_cyc[$];
   logic [31:0] rise_addr[$];
   logic        rise_we[$];
   logic [31:0] rise_wdata[$];
   int          done_cyc[$];
   logic [3:0]  done_val[$];
   logic [31:0] done_load[$];
   logic        done_lock[$];
   int          err_cnt;
   int          stab_cnt;
   logic        prev_req;

   function automatic access_t mk(int id, bit r, bit w, bit rt, bit wt,
                                  logic [31:0] ptr, logic [31:0] data,
                                  logic [31:0] rdata, int delay);
      access_t a;
      a.id = 3'(id); a.r = r; a.w = w; a.rt = rt; a.wt = wt;
      a.ptr = ptr; a.data = data; a.rdata = rdata; a.delay = 8'(delay);
      return a;
   endfunction

   function automatic int head_idx(int i);
      for (int k = 0; k < pend_q.size(); k++)
         if (int'(pend_q[k].id) == i) return k;
      return -1;
   endfunction

   function automatic int pick();
      if (m_lock) return (head_idx(m_gid) >= 0) ? m_gid : -1;
      for (int k = 1; k <= N; k++)
         if (head_idx((m_gid + k) % N) >= 0) return (m_gid + k) % N;
      return -1;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_inputs(bit jit);
      for (int i = 0; i < N; i++) begin
         int h;
         h = head_idx(i);
         if (h >= 0) begin
            req_avail[i] = 1'b1;
            req_r_en[i] = pend_q[h].r;
            req_w_en[i] = pend_q[h].w;
            req_read_through[i] = pend_q[h].rt;
            req_write_through[i] = pend_q[h].wt;
            req_ptr[i*AW +: AW] = pend_q[h].ptr;
            req_data_store[i*DW +: DW] = pend_q[h].data;
         end else begin
            req_avail[i] = 1'b0;
            req_r_en[i] = 1'b0;
            req_w_en[i] = 1'b0;
            req_read_through[i] = 1'b0;
            req_write_through[i] = 1'b0;
            req_ptr[i*AW +: AW] = '0;
            req_data_store[i*DW +: DW] = '0;
         end
         if (jit) begin
            req_ptr[i*AW +: AW] = $urandom;
            req_data_store[i*DW +: DW] = $urandom;
         end
      end
   endtask

   task automatic model_reset();
      m_gid = N - 1; m_lock = 0; m_load = '0;
      m_act = 0; m_acked = 0; m_first = 0; m_cnt = 0;
   endtask

   task automatic clear_logs();
      dut_grants.delete(); rise_cyc.delete(); rise_addr.delete(); rise_we.delete();
      rise_wdata.delete(); done_cyc.delete(); done_val.delete(); done_load.delete();
      done_lock.delete(); err_cnt = 0; stab_cnt = 0;
   endtask

   // Decide what the requesters and memory present for the rest of this cycle.
   task automatic advance();
      int w;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (!rst_l) begin
         drive_inputs(0);
      end else if (m_act && m_acked) begin
         w = head_idx(m_gid);
         if (w >= 0) pend_q.delete(w);
         if (m_tx.w && m_tx.wt) m_lock = 0;
         m_act = 0;
         drive_inputs(0);
      end else if (m_act) begin
         m_first = 0;
         if (m_cnt == int'(m_tx.delay)) begin
            mem_ack = 1'b1;
            mem_rdata = m_tx.rdata;
            m_acked = 1;
            if (!m_tx.w) m_load = m_tx.rdata;
            if (!m_tx.w && m_tx.rt) m_lock = 1;
         end else begin
            m_cnt++;
         end
         drive_inputs(jitter);
      end else begin
         drive_inputs(0);
         w = pick();
         if (w >= 0) begin
            m_tx = pend_q[head_idx(w)];
            m_gid = w; m_act = 1; m_acked = 0; m_first = 1; m_cnt = 0;
         end
      end
   endtask

   // The single compare point: outputs sampled mid-cycle against the model.
   task automatic step();
      logic [63:0] exp_done;
      @(negedge clk);
      cyc++;
      exp_done = (m_act && m_acked) ? (64'd1 << m_gid) : 64'd0;
      chk("mem_req", 64'(mem_req), 64'(m_act && !m_acked));
      if (m_act && !m_acked) begin
         chk("mem_we", 64'(mem_we), 64'(m_tx.w));
         chk("mem_addr", 64'(mem_addr), 64'(m_tx.ptr));
         chk("mem_wdata", 64'(mem_wdata), 64'(m_tx.data));
      end
      chk("req_done", 64'(req_done), exp_done);
      chk("req_data_load", 64'(req_data_load), 64'(m_load));
      chk("lock_active", 64'(lock_active), 64'(m_lock));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      chk("err_both", 64'(err_both), 64'(m_act && m_first && m_tx.r && m_tx.w));
      if (mem_req && !prev_req) begin
         dut_grants.push_back(int'(grant_id));
         rise_cyc.push_back(cyc);
         rise_addr.push_back(mem_addr);
         rise_we.push_back(mem_we);
         rise_wdata.push_back(mem_wdata);
      end
      prev_req = mem_req;
      if (req_done != '0) begin
         done_cyc.push_back(cyc);
         done_val.push_back(req_done);
         done_load.push_back(req_data_load);
         done_lock.push_back(lock_active);
      end
      if (err_both) err_cnt++;
      if (mem_req && mem_addr == 32'h80) stab_cnt++;
      advance();
   endtask

   task automatic run_until_idle(int budget);
      int n;
      n = 0;
      while ((m_act || pend_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      if (m_act || pend_q.size() != 0) begin
         n_checks++;
         n_err++;
         $display("FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
      end
   endtask

   task automatic reset_dut();
      rst_l = 1'b0;
      jitter = 0;
      pend_q.delete();
      model_reset();
      advance();
      repeat (2) step();
      chk("reset_grant_id", 64'(grant_id), 64'd3);
      chk("reset_mem_req", 64'(mem_req), 64'd0);
      clear_logs();
   endtask

   task automatic release_reset();
      rst_l = 1'b1;
      advance();
   endtask

   initial begin
      prev_req = 1'b0;
      model_reset();
      clear_logs();

      // single read, memory answers on the fourth MEM cycle
      reset_dut();
      pend_q.push_back(mk(1, 1, 0, 0, 0, 32'h40, 32'h0, 32'hDEADBEEF, 3));
      release_reset();
      run_until_idle(50);
      chk("rd_grant_count", 64'(dut_grants.size()), 64'd1);
      chk("rd_done_count", 64'(done_val.size()), 64'd1);
      if (dut_grants.size() == 1 && done_val.size() == 1) begin
         chk("rd_grant", 64'(dut_grants[0]), 64'd1);
         chk("rd_addr", 64'(rise_addr[0]), 64'h40);
         chk("rd_we", 64'(rise_we[0]), 64'd0);
         chk("rd_done", 64'(done_val[0]), 64'b0010);
         chk("rd_load", 64'(done_load[0]), 64'hDEADBEEF);
         chk("rd_latency", 64'(done_cyc[0] - rise_cyc[0]), 64'd4);
      end

      // round-robin from reset, immediate ack, ptr/data scrambled during MEM
      reset_dut();
      jitter = 1;
      pend_q.push_back(mk(0, 1, 0, 0, 0, 32'h100, 32'h0, 32'hA0, 0));
      pend_q.push_back(mk(1, 1, 0, 0, 0, 32'h104, 32'h0, 32'hA1, 0));
      pend_q.push_back(mk(2, 1, 0, 0, 0, 32'h108, 32'h0, 32'hA2, 0));
      pend_q.push_back(mk(3, 1, 0, 0, 0, 32'h10C, 32'h0, 32'hA3, 0));
      pend_q.push_back(mk(0, 1, 0, 0, 0, 32'h110, 32'h0, 32'hA4, 0));
      release_reset();
      run_until_idle(100);
      chk("rr_grant_count", 64'(dut_grants.size()), 64'd5);
      chk("rr_done_count", 64'(done_cyc.size()), 64'd5);
      if (dut_grants.size() == 5 && done_cyc.size() == 5) begin
         chk("rr_g0", 64'(dut_grants[0]), 64'd0);
         chk("rr_g1", 64'(dut_grants[1]), 64'd1);
         chk("rr_g2", 64'(dut_grants[2]), 64'd2);
         chk("rr_g3", 64'(dut_grants[3]), 64'd3);
         chk("rr_g4", 64'(dut_grants[4]), 64'd0);
         for (int k = 0; k < 4; k++)
            chk("rr_spacing", 64'(done_cyc[k+1] - done_cyc[k]), 64'd3);
      end

      // RMW lock: req2 read_through, read_through again, plain write, write_through; req0 waits
      reset_dut();
      jitter = 1;
      pend_q.push_back(mk(2, 1, 0, 1, 0, 32'h10, 32'h0, 32'h11, 1));
      release_reset();
      pend_q.push_back(mk(0, 1, 0, 0, 0, 32'h20, 32'h0, 32'h55, 0));
      pend_q.push_back(mk(2, 1, 0, 1, 0, 32'h10, 32'h0, 32'h22, 0));
      pend_q.push_back(mk(2, 0, 1, 0, 0, 32'h10, 32'h33, 32'h0, 2));
      pend_q.push_back(mk(2, 0, 1, 0, 1, 32'h10, 32'h44, 32'h0, 0));
      run_until_idle(100);
      chk("lk_grant_count", 64'(dut_grants.size()), 64'd5);
      chk("lk_done_count", 64'(done_lock.size()), 64'd5);
      if (dut_grants.size() == 5 && done_lock.size() == 5) begin
         for (int k = 0; k < 4; k++) begin
            chk("lk_grant_req2", 64'(dut_grants[k]), 64'd2);
            chk("lk_lock_at_done", 64'(done_lock[k]), 64'd1);
         end
         chk("lk_grant_req0", 64'(dut_grants[4]), 64'd0);
         chk("lk_lock_released", 64'(done_lock[4]), 64'd0);
         chk("lk_req0_load", 64'(done_load[4]), 64'h55);
      end

      // read and write both set on req3: write wins, err_both pulses once
      reset_dut();
      pend_q.push_back(mk(3, 1, 1, 0, 0, 32'h30, 32'h5, 32'hFF, 1));
      release_reset();
      run_until_idle(50);
      chk("eb_err_count", 64'(err_cnt), 64'd1);
      chk("eb_grant_count", 64'(dut_grants.size()), 64'd1);
      chk("eb_done_count", 64'(done_val.size()), 64'd1);
      if (dut_grants.size() == 1 && done_val.size() == 1) begin
         chk("eb_we", 64'(rise_we[0]), 64'd1);
         chk("eb_wdata", 64'(rise_wdata[0]), 64'h5);
         chk("eb_done", 64'(done_val[0]), 64'b1000);
         chk("eb_load_untouched", 64'(done_load[0]), 64'h0);
      end

      // address held while req_ptr[0] changes during a long memory wait
      reset_dut();
      jitter = 1;
      pend_q.push_back(mk(0, 1, 0, 0, 0, 32'h80, 32'h0, 32'h77, 4));
      release_reset();
      run_until_idle(50);
      chk("st_addr_cycles", 64'(stab_cnt), 64'd5);

      // reset during MEM abandons the access; requester 0 wins first afterwards
      reset_dut();
      pend_q.push_back(mk(2, 1, 0, 0, 0, 32'h50, 32'h0, 32'h99, 6));
      release_reset();
      pend_q.push_back(mk(0, 1, 0, 0, 0, 32'h60, 32'h0, 32'h61, 0));
      step();
      step();
      rst_l = 1'b0;
      #1;
      chk("rm_mem_req_now", 64'(mem_req), 64'd0);
      chk("rm_done_now", 64'(req_done), 64'd0);
      mem_ack = 1'b0;
      model_reset();
      step();
      step();
      chk("rm_no_done", 64'(done_val.size()), 64'd0);
      clear_logs();
      release_reset();
      run_until_idle(100);
      chk("rm_grant_count", 64'(dut_grants.size()), 64'd2);
      if (dut_grants.size() == 2) begin
         chk("rm_first_grant", 64'(dut_grants[0]), 64'd0);
         chk("rm_second_grant", 64'(dut_grants[1]), 64'd2);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one scratchpad memory port between NUM_REQ mem_handle-style requesters, e.g. the four handles of a convolution backward unit, or several FPU ops.
- Round-robin grant with a read-modify-write lock: a read_through read holds the port for the same requester until its write_through write completes.
- Sits between the FPU op blocks and the memory controller.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, pointer width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
req_avail  in  NUM_REQ  requester i has an access pending
req_r_en  in  NUM_REQ  read request
req_w_en  in  NUM_REQ  write request
req_read_through  in  NUM_REQ  read opens RMW lock
req_write_through  in  NUM_REQ  write closes RMW lock
req_ptr  in  NUM_REQ*ADDR_W  per-requester address
req_data_store  in  NUM_REQ*DATA_W  per-requester write data
req_done  out  NUM_REQ  one-cycle completion pulse to requester i
req_data_load  out  DATA_W  read data; valid when any req_done bit is high
mem_req  out  1  memory access request
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion; read data valid same cycle
mem_rdata  in  DATA_W  memory read data
lock_active  out  1  RMW lock held
grant_id  out  clog2(NUM_REQ)  index of current/last grantee
err_both  out  1  one-cycle pulse: granted request had r_en and w_en both set

Behaviour:
- Reset (async, rst_l low), registered outputs:
  - req_done=0, req_data_load=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, lock_active=0, err_both=0.
  - grant_id=NUM_REQ-1, so the first search starts at 0.
  - State goes to ARB.
- Reset mid-access abandons it; no req_done is issued.
- Eligible requester i: req_avail[i] && (req_r_en[i] || req_w_en[i]).
- States:
  - ARB:
    - Lock clear: search eligible requesters in order grant_id+1, grant_id+2, ... (mod NUM_REQ); take the first.
    - Lock set: only the locked grant_id is eligible; all others wait.
    - On a grant, capture ptr, data_store, r/w and through bits into holding registers; set grant_id; set mem_req=1, mem_we=w_en, mem_addr, mem_wdata; go to MEM.
    - If both r_en and w_en are set, w_en wins and err_both pulses.
    - No eligible requester: stay in ARB.
  - MEM:
    - mem_req, mem_we, mem_addr, mem_wdata stay stable until mem_ack.
    - On mem_ack: mem_req=0; for a read, req_data_load<=mem_rdata; go to RESP.
  - RESP:
    - req_done[grant_id]=1 for exactly this cycle; all other bits 0.
    - req_data_load holds its value until the next read completes.
    - Lock update on this cycle: a read with read_through sets lock_active; a write with write_through clears it.
    - Go to ARB.
- Requester contract: on seeing req_done at a clock edge, the requester drops avail/r_en/w_en on the next cycle.
  - RESP->ARB timing guarantees the same request is never granted twice.
- Minimum latency: grant cycle to req_done = 2 cycles plus memory wait. With mem_ack in the first MEM cycle, req_done is high 2 cycles after the ARB grant cycle.
- Throughput: at most one access per 3 cycles.
- Inputs are sampled only in ARB. Changes to ptr/data while in MEM/RESP are ignored.
- Lock edge cases:
  - A locked requester issuing a read_through read keeps the lock.
  - A plain write from the locked requester completes and the lock stays set.
  - The lock never times out; releasing it is the requester's responsibility.
- Round-robin is fair: every eligible unlocked requester is granted within NUM_REQ accesses.

Test Plan:
- Single read: req1 reads ptr 0x40, mem_ack 3 cycles later with 0xDEADBEEF -> mem_addr=0x40, mem_we=0, req_done=0010 one cycle, req_data_load=0xDEADBEEF.
- Round-robin: reqs 0,1,2,3 all hold reads from reset, ack immediate -> grant order 0,1,2,3,0; each req_done 3 cycles apart.
- RMW lock: req2 does a read_through read of 0x10 while req0 waits; req2 then writes 0x10 with write_through -> req0 not granted until after req2's write req_done; lock_active high from req2's read RESP through its write RESP.
- Simultaneous r_en and w_en on req3, data 0x5 -> mem_we=1, mem_wdata=0x5, err_both pulses once, req_done[3] pulses.
- Input stability: change req_ptr[0] during MEM -> mem_addr holds its captured value until mem_ack.
- Reset mid-access: rst_l low during MEM -> mem_req=0 immediately, no req_done; after release, first grant goes to requester 0.
